axi_lite_cmd_queue: RTL and testbench
=====================================

Name: axi_lite_cmd_queue

Overview:
- Upstream command front-end for axi_lite_top. Buffers write/read requests from a producer in a small FIFO and issues them one at a time as start_write/start_read pulses with stable address/data.
- Detects write_done/read_done for each issued command and returns a response (read data, optional error) over a valid/ready channel.
- Lets software-side logic queue back-to-back transactions without violating axi_lite_top's single-outstanding rule.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 256, cycles to wait for done before erroring; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- cmd_valid  in  1  producer command valid.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  timeout error flag.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- start_write  out  1  one-cycle pulse to axi_lite_top.
- start_read  out  1  one-cycle pulse to axi_lite_top.
- write_address_M  out  ADDR_W  write address to axi_lite_top.
- write_data  out  DATA_W  write data to axi_lite_top.
- read_address  out  ADDR_W  read address to axi_lite_top.
- read_data  in  DATA_W  from axi_lite_top.
- write_done  in  1  from axi_lite_top; level or pulse.
- read_done  in  1  from axi_lite_top; level or pulse.

Behaviour:
- **Reset** (rst high at posedge):
  - FIFO flushed; level=0, cmd_ready=1.
  - FSM goes to IDLE.
  - All outputs 0, including start_*, rsp_*, addresses and data.
  - Done-edge registers cleared.
  - A reset mid-transaction abandons the transaction and produces no response.
- **FIFO push and pop:**
  - Push when cmd_valid & cmd_ready.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - When full, cmd_ready=0 and cmd_valid is ignored.
  - Push and pop in the same cycle leaves level unchanged.
- **FSM IDLE:**
  - If level!=0, pop the head into holding registers and go to ISSUE.
  - Drive the command's address onto write_address_M (write) or read_address (read), and write data onto write_data.
  - The unused address output holds its previous value.
- **FSM ISSUE:** assert exactly one of start_write/start_read for one cycle, then go to WAIT.
  - Net effect: a command pushed at edge N gives a start pulse during the cycle after edge N+2, with the FIFO previously empty and the FSM in IDLE.
- **FSM WAIT:**
  - Completion is the rising edge of the matching done signal: done & !done_q, with done_q registered every cycle.
  - The non-matching done signal is ignored.
  - A done already high at ISSUE does not complete until it falls and rises again.
  - On completion, capture read_data (reads) or 0 (writes) into rsp_rdata, set rsp_err=0, go to RESP.
- **FSM RESP:**
  - rsp_valid=1; rsp_write, rsp_rdata and rsp_err held stable.
  - On rsp_ready, drop rsp_valid next cycle and go to IDLE.
  - rsp_ready asserted early is allowed; a response completes in 1 cycle.
- **Ordering and holds:**
  - Only one command is outstanding; responses come back in command order.
  - Addresses and write data remain stable from IDLE pop until the next pop.
- **Throughput:** minimum 4 cycles per command (IDLE, ISSUE, WAIT≥1, RESP≥1).

Optional Feature:
- Macro: AXIL_CMDQ_TIMEOUT_EN.
- **Defined:**
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without completion, go to RESP with rsp_err=1 and rsp_rdata=0.
  - A done edge in the same cycle as expiry wins: rsp_err=0.
- **Undefined:**
  - No counter; WAIT is held indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- **Single write:** push write addr 0x10, data 0xA5A5A5A5; write_done rises 5 cycles after start_write.
  - start_write is a 1-cycle pulse 2 cycles after accept, with write_address_M=0x10 and write_data=0xA5A5A5A5.
  - One response: rsp_write=1, rsp_rdata=0, rsp_err=0.
- **Single read:** push read addr 0x10; read_data=0xA5A5A5A5 with read_done.
  - start_read pulse, read_address=0x10.
  - Response: rsp_write=0, rsp_rdata=0xA5A5A5A5.
- **Back-to-back commands:** push writes 0x30/0x11223344 and 0x40/0x55667788, then reads 0x30 and 0x40, on consecutive cycles.
  - Exactly four start pulses in push order, each after the previous response is accepted.
  - Read responses are 0x11223344 then 0x55667788.
- **Full and wrap:** hold write_done low and push 6 commands with DEPTH=4.
  - cmd_ready drops after 5 accepts (4 in FIFO plus 1 popped into the holding registers).
  - Releasing done drains all 5 in order; pointer wrap is verified.
- **Done-level and backpressure:** write_done held high continuously from a previous transaction, and rsp_ready held low for 10 cycles.
  - No completion until write_done falls and rises again.
  - rsp_valid and rsp_rdata stable for all 10 cycles.
  - No new start pulse during that time.
- **Reset and timeout:**
  - rst asserted in WAIT → all outputs 0 next cycle, level=0, no response.
  - With AXIL_CMDQ_TIMEOUT_EN and TIMEOUT=16, a read with no read_done → response rsp_err=1, rsp_rdata=0, 16 cycles after entering WAIT.

Source files
------------

// File: rtl/axi_lite_cmd_queue.sv
// -----------------------------------------------------------------------------
// axi_lite_cmd_queue
//
// Command front-end for axi_lite_top. Write/read requests from a producer are
// buffered in a DEPTH-entry FIFO and issued one at a time as single-cycle
// start_write/start_read pulses. Address and data stay stable until the next
// pop. Completion is the rising edge of the matching done input. Each command
// returns one response (echoed type, read data, error flag) on a valid/ready
// channel, in command order.
//
// Optional feature: define AXIL_CMDQ_TIMEOUT_EN to give up on a command that
// sees no done edge within TIMEOUT cycles of WAIT. Such a command responds
// with rsp_err=1 and rsp_rdata=0. Without the macro, WAIT has no time limit
// and rsp_err is tied to 0.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata  producer command channel (ready = !full)
//   rsp_valid/ready/write/rdata/err   response channel to the consumer
//   level                         FIFO occupancy (0..DEPTH)
//   start_write, start_read       one-cycle issue pulses to axi_lite_top
//   write_address_M, write_data   write command operands to axi_lite_top
//   read_address                  read command address to axi_lite_top
//   read_data, write_done, read_done  completion inputs from axi_lite_top
// -----------------------------------------------------------------------------
module axi_lite_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      start_write,
  output logic                      start_read,
  output logic [ADDR_W-1:0]         write_address_M,
  output logic [DATA_W-1:0]         write_data,
  output logic [ADDR_W-1:0]         read_address,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      write_done,
  input  logic                      read_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  state_e           state_q;
  logic             push, pop;
  cmd_t             head;

  assign cmd_ready = (level_q != LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign level     = level_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage is not reset; level_q alone decides which entries are live,
  // so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  // NOTE: non-blocking assignments for all sequential state, so every block
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue / completion FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic              is_write_q;
  logic              start_write_q, start_read_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
  logic              rsp_valid_q;
  logic              wdone_q, rdone_q;
  logic              done_edge;

  // Only the done that matches the outstanding command counts. A done that is
  // already high when the command issues must fall and rise again.
  assign done_edge = is_write_q ? (write_done && !wdone_q) : (read_done && !rdone_q);

`ifdef AXIL_CMDQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      is_write_q    <= 1'b0;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      raddr_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      wdone_q       <= 1'b0;
      rdone_q       <= 1'b0;
`ifdef AXIL_CMDQ_TIMEOUT_EN
      tmr_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      wdone_q       <= write_done;
      rdone_q       <= read_done;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            is_write_q <= head.write;
            // The address output of the other command type keeps its value.
            if (head.write) begin
              waddr_q <= head.addr;
              wdata_q <= head.wdata;
            end else begin
              raddr_q <= head.addr;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_write_q <= is_write_q;
          start_read_q  <= !is_write_q;
`ifdef AXIL_CMDQ_TIMEOUT_EN
          tmr_q         <= '0;
`endif
          state_q       <= WAIT;
        end
        WAIT: begin
          if (done_edge) begin
            rsp_rdata_q <= is_write_q ? '0 : read_data;
            rsp_valid_q <= 1'b1;
`ifdef AXIL_CMDQ_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= RESP;
          end
`ifdef AXIL_CMDQ_TIMEOUT_EN
          // A done edge in the expiry cycle takes the branch above.
          else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_write     = start_write_q;
  assign start_read      = start_read_q;
  assign write_address_M = waddr_q;
  assign write_data      = wdata_q;
  assign read_address    = raddr_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = is_write_q;
  assign rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_axi_lite_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_cmd_queue
//
// Scoreboard bench for axi_lite_cmd_queue. The monitor records every accepted
// command. It pushes the expected issue (type, address, data) and the expected
// response into queues. The expected response comes from a simple memory
// model: a read returns the last data written to that address, in command
// order. A separate responder plays axi_lite_top. It stores writes, answers
// reads from its own memory, and raises done after a delay. Directed phases
// cover reset, latency, back-to-back issue, full/wrap, done-level and
// backpressure, and mid-transaction reset. A randomized phase follows, and
// the timeout case runs when AXIL_CMDQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_axi_lite_cmd_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]          cmd_addr;
  logic [DW-1:0]          cmd_wdata;
  logic                   rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0]          rsp_rdata;
  logic [$clog2(DEPTH):0] level;
  logic                   start_write, start_read;
  logic [AW-1:0]          write_address_M, read_address;
  logic [DW-1:0]          write_data, read_data;
  logic                   write_done, read_done;

  always #5 clk = ~clk;

  axi_lite_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .level(level),
    .start_write(start_write), .start_read(start_read),
    .write_address_M(write_address_M), .write_data(write_data),
    .read_address(read_address), .read_data(read_data),
    .write_done(write_done), .read_done(read_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {logic write; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_s;
  typedef struct {logic write; logic [DW-1:0] rdata; logic err;} rsp_s;

  cmd_s          exp_cmd[$];
  rsp_s          exp_rsp[$];
  logic [DW-1:0] model_mem[logic [AW-1:0]];

  int   cyc = 0;
  int   n_acc = 0, n_starts = 0, n_rsp = 0;
  int   acc_cyc = 0, last_start_cyc = 0, rsp_rise_cyc = 0;
  logic [DW-1:0] last_rdata = '0;
  logic last_write = 1'b0;
  bit   outstanding = 1'b0;
  bit   rsp_valid_prev = 1'b0;
  bit   expect_timeout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    cmd_s c;
    rsp_s r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cmd.delete();
        exp_rsp.delete();
        outstanding = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          c = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
          r = '{write: cmd_write, rdata: '0, err: 1'b0};
          if (cmd_write) begin
            model_mem[cmd_addr] = cmd_wdata;
          end else if (expect_timeout) begin
            r.err = 1'b1;
          end else begin
            r.rdata = model_mem.exists(cmd_addr) ? model_mem[cmd_addr] : init_val(cmd_addr);
          end
          exp_cmd.push_back(c);
          exp_rsp.push_back(r);
          n_acc++;
          acc_cyc = cyc + 1;
        end
        if (start_write || start_read) begin
          check("start_onehot", {1'b0, start_write & start_read}, 0);
          check("start_while_busy", {1'b0, outstanding}, 0);
          if (exp_cmd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL start_unexpected: start with no queued command at t=%0t", $time);
          end else begin
            c = exp_cmd.pop_front();
            check("start_type", {1'b0, start_write}, {1'b0, c.write});
            if (c.write) begin
              check("start_waddr", write_address_M, c.addr);
              check("start_wdata", write_data, c.wdata);
            end else begin
              check("start_raddr", read_address, c.addr);
            end
          end
          outstanding = 1'b1;
          n_starts++;
          last_start_cyc = cyc;
        end
        if (rsp_valid && !rsp_valid_prev) rsp_rise_cyc = cyc;
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: response with none expected at t=%0t", $time);
          end else begin
            r = exp_rsp.pop_front();
            check("rsp_write", {1'b0, rsp_write}, {1'b0, r.write});
            check("rsp_rdata", rsp_rdata, r.rdata);
            check("rsp_err", {1'b0, rsp_err}, {1'b0, r.err});
          end
          check("rsp_without_start", {1'b0, outstanding}, 1);
          outstanding = 1'b0;
          n_rsp++;
          last_rdata = rsp_rdata;
          last_write = rsp_write;
        end
      end
      rsp_valid_prev = rsp_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // axi_lite_top stand-in
  // ---------------------------------------------------------------------------
  bit            auto_en = 1'b1;
  bit            man_en = 1'b0, man_wdone = 1'b0, man_rdone = 1'b0;
  int            fix_delay = 0;
  logic [DW-1:0] slave_mem[logic [AW-1:0]];

  initial begin : responder
    bit            pending;
    bit            p_write;
    logic [DW-1:0] p_data;
    int            dly, hold;
    pending = 1'b0; p_write = 1'b0; p_data = '0; dly = 0; hold = 0;
    write_done = 1'b0; read_done = 1'b0; read_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        pending = 1'b0; hold = 0;
        write_done = 1'b0; read_done = 1'b0;
      end else begin
        if (start_write) begin
          slave_mem[write_address_M] = write_data;
          p_write = 1'b1;
        end
        if (start_read) begin
          p_data  = slave_mem.exists(read_address) ? slave_mem[read_address] : init_val(read_address);
          p_write = 1'b0;
        end
        if ((start_write || start_read) && !man_en) begin
          pending = 1'b1;
          dly     = (fix_delay != 0) ? fix_delay : int'($urandom_range(1, 6));
        end
        if (man_en) begin
          write_done = man_wdone;
          read_done  = man_rdone;
          read_data  = $urandom;
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) begin
            write_done = 1'b0;
            read_done  = 1'b0;
          end
        end else if (pending && auto_en && dly <= 1) begin
          pending = 1'b0;
          if (p_write) write_done = 1'b1;
          else begin
            read_done = 1'b1;
            read_data = p_data;
          end
          hold = int'($urandom_range(1, 3));
        end else begin
          if (pending && auto_en) dly--;
          read_data = $urandom;
        end
      end
    end
  end

  // rdy_mode: 0 = always ready, 1 = random, 2 = held low.
  int rdy_mode = 0;
  initial begin : rsp_ready_driver
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int bound, output bit ok);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push_chk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    push(w, a, d, 200, ok);
    check("push_accepted", {63'd0, ok}, 1);
  endtask

  task automatic wait_start(input int prev, input int bound);
    int i;
    for (i = 0; i < bound && n_starts <= prev; i++) step(1);
    check("start_seen", n_starts, prev + 1);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && n_rsp != n_acc; i++) step(1);
    check("drain", n_rsp, n_acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_cmd_ready"}, {1'b0, cmd_ready}, 1);
    check({tag, "_rsp_valid"}, {1'b0, rsp_valid}, 0);
    check({tag, "_rsp_write"}, {1'b0, rsp_write}, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, {1'b0, rsp_err}, 0);
    check({tag, "_starts"}, {start_write, start_read}, 0);
    check({tag, "_waddr"}, write_address_M, 0);
    check({tag, "_wdata"}, write_data, 0);
    check({tag, "_raddr"}, read_address, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int  s0, s1, r0, acc_ok;
    bit  ok;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // Single write: start two edges after accept, response is (1, 0, 0).
    fix_delay = 5;
    push_chk(1'b1, 32'h10, 32'hA5A5_A5A5);
    wait_drain(100);
    check("wr_latency", last_start_cyc - acc_cyc, 2);
    check("wr_rsp_write", {1'b0, last_write}, 1);
    check("wr_rsp_rdata", last_rdata, 0);

    // Single read returns the data just written.
    fix_delay = 0;
    push_chk(1'b0, 32'h10, 32'h0);
    wait_drain(100);
    check("rd_rsp_write", {1'b0, last_write}, 0);
    check("rd_rsp_rdata", last_rdata, 32'hA5A5_A5A5);

    // Back-to-back pushes on consecutive cycles.
    s0 = n_starts;
    push_chk(1'b1, 32'h30, 32'h1122_3344);
    push_chk(1'b1, 32'h40, 32'h5566_7788);
    push_chk(1'b0, 32'h30, 32'h0);
    push_chk(1'b0, 32'h40, 32'h0);
    wait_drain(300);
    check("b2b_starts", n_starts - s0, 4);
    check("b2b_last_rdata", last_rdata, 32'h5566_7788);

    // Full and wrap: 4 in the FIFO plus 1 held, sixth refused.
    auto_en = 1'b0;
    fix_delay = 1;
    s0 = n_starts;
    acc_ok = 0;
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 32'h100 + 32'(4 * i), $urandom, 3, ok);
      acc_ok += int'(ok);
    end
    check("full_accepts", acc_ok, 5);
    check("full_level", level, DEPTH);
    check("full_ready", {1'b0, cmd_ready}, 0);
    auto_en = 1'b1;
    wait_drain(300);
    check("full_starts", n_starts - s0, 5);
    check("full_level_empty", level, 0);
    fix_delay = 0;

    // Done held high from a previous transaction, then backpressure.
    man_en = 1'b1; man_wdone = 1'b0;
    s0 = n_starts;
    push_chk(1'b1, 32'h50, 32'hCAFE_0050);
    wait_start(s0, 20);
    step(2);
    man_wdone = 1'b1;
    wait_drain(50);
    rdy_mode = 2;
    s0 = n_starts;
    push_chk(1'b1, 32'h54, 32'hCAFE_0054);
    wait_start(s0, 20);
    step(6);
    check("lvl_no_complete", {1'b0, rsp_valid}, 0);
    man_wdone = 1'b0;
    step(1);
    man_wdone = 1'b1;
    for (int i = 0; i < 10 && !rsp_valid; i++) step(1);
    check("lvl_completed", {1'b0, rsp_valid}, 1);
    push_chk(1'b1, 32'h58, 32'hCAFE_0058);
    s1 = n_starts;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_valid", {1'b0, rsp_valid}, 1);
      check("bp_rdata", rsp_rdata, 0);
      check("bp_no_start", n_starts, s1);
    end
    rdy_mode = 0;
    wait_start(s1, 20);
    man_wdone = 1'b0;
    step(1);
    man_wdone = 1'b1;
    step(1);
    man_wdone = 1'b0;
    step(1);
    man_en = 1'b0;
    wait_drain(50);

    // Reset while in WAIT abandons the read with no response.
    auto_en = 1'b0;
    s0 = n_starts;
    push_chk(1'b0, 32'h10, 32'h0);
    wait_start(s0, 20);
    step(2);
    r0 = n_rsp;
    rst = 1'b1;
    step(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    auto_en = 1'b1;
    step(15);
    check("midrst_no_rsp", n_rsp, r0);
    check("midrst_rsp_valid", {1'b0, rsp_valid}, 0);
    n_acc = n_rsp;

    // Randomized traffic with random response backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 2));
      push_chk(1'($urandom_range(0, 1)), {27'd0, 3'($urandom_range(0, 7)), 2'b00}, $urandom);
    end
    wait_drain(5000);
    rdy_mode = 0;
    step(2);

`ifdef AXIL_CMDQ_TIMEOUT_EN
    // Read with no read_done: error response TIMEOUT cycles after WAIT entry.
    auto_en = 1'b0;
    expect_timeout = 1'b1;
    s0 = n_starts;
    push_chk(1'b0, 32'h24, 32'h0);
    expect_timeout = 1'b0;
    wait_start(s0, 20);
    for (int i = 0; i < 40 && !rsp_valid; i++) step(1);
    check("tmo_latency", rsp_rise_cyc - last_start_cyc, TMO);
    check("tmo_err", {1'b0, rsp_err}, 1);
    check("tmo_rdata", rsp_rdata, 0);
    wait_drain(20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
